// File: rtl/synaptic_current_integrator_if.sv
// Spike, weight-config and current-output signals of the synaptic integrator.
// The master modport drives stimulus and config; the slave modport is the integrator.
interface synaptic_current_integrator_if #(
    parameter int N_INPUTS = 4
);
    localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;

    logic                  enable;
    logic [N_INPUTS-1:0]   spike_in;
    logic                  cfg_valid;
    logic                  cfg_ready;
    logic [AW-1:0]         cfg_addr;
    logic [7:0]            cfg_data;
    logic [7:0]            current_out;
    logic                  current_valid;

    modport master (
        output enable, spike_in, cfg_valid, cfg_addr, cfg_data,
        input  cfg_ready, current_out, current_valid
    );

    modport slave (
        input  enable, spike_in, cfg_valid, cfg_addr, cfg_data,
        output cfg_ready, current_out, current_valid
    );
endinterface

// File: rtl/synaptic_current_integrator.sv
// Spikes x signed weights into a leaky, saturating 8-bit synaptic current; SYN_EVENT_COUNT_EN adds event_count.
// Latency: step on cycle t updates current_out/current_valid at edge t+1.
// Backpressure: config writes stall (cfg_ready=0) while enable is high; spikes are never dropped.
module synaptic_current_integrator #(
    parameter int N_INPUTS  = 4,
    parameter int TAU_SHIFT = 3
) (
    input  logic                          clk,
    input  logic                          reset_n,
    synaptic_current_integrator_if.slave  bus
`ifdef SYN_EVENT_COUNT_EN
    ,
    output logic [15:0]                   event_count
`endif
);
    localparam int AW = (N_INPUTS > 1) ? $clog2(N_INPUTS) : 1;
    // One bit wider than the nominal 11 so an all-weights full-scale sum at N=8 cannot wrap before clamping.
    localparam int SW = 12;

    logic signed [7:0]    weight_q [N_INPUTS];
    logic [N_INPUTS-1:0]  pending_q, pending_d;
    logic [N_INPUTS-1:0]  eff;
    logic signed [7:0]    i_q, i_d;
    logic                 valid_q, valid_d;
    logic signed [SW-1:0] i_ext, leak, sum;
    logic                 cfg_wr;

    assign bus.cfg_ready     = ~bus.enable;
    assign bus.current_out   = i_q;
    assign bus.current_valid = valid_q;
    assign cfg_wr            = bus.cfg_valid & ~bus.enable;

    always_comb begin
        eff       = pending_q | bus.spike_in;
        pending_d = bus.enable ? '0 : eff;
        valid_d   = bus.enable;
        i_ext     = {{(SW-8){i_q[7]}}, i_q};
        // Arithmetic shift floors, so small negative currents decay all the way to zero.
        leak      = i_ext - (i_ext >>> TAU_SHIFT);
        sum       = leak;
        for (int i = 0; i < N_INPUTS; i++) begin
            if (eff[i]) begin
                sum = sum + {{(SW-8){weight_q[i][7]}}, weight_q[i]};
            end
        end
        i_d = i_q;
        if (bus.enable) begin
            if (sum > SW'(127)) begin
                i_d = 8'sd127;
            end else if (sum < -SW'(128)) begin
                i_d = -8'sd128;
            end else begin
                i_d = sum[7:0];
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < N_INPUTS; i++) begin
                weight_q[i] <= '0;
            end
            pending_q <= '0;
            i_q       <= '0;
            valid_q   <= 1'b0;
        end else begin
            for (int i = 0; i < N_INPUTS; i++) begin
                if (cfg_wr && bus.cfg_addr == AW'(i)) begin
                    weight_q[i] <= bus.cfg_data;
                end
            end
            pending_q <= pending_d;
            i_q       <= i_d;
            valid_q   <= valid_d;
        end
    end

`ifdef SYN_EVENT_COUNT_EN
    logic [15:0] event_cnt_q, event_cnt_d;
    logic [4:0]  pop;
    logic [16:0] cnt_sum;

    always_comb begin
        pop = '0;
        for (int i = 0; i < N_INPUTS; i++) begin
            pop = pop + {4'd0, eff[i]};
        end
        cnt_sum     = {1'b0, event_cnt_q} + {12'd0, pop};
        event_cnt_d = event_cnt_q;
        if (bus.enable) begin
            event_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            event_cnt_q <= '0;
        end else begin
            event_cnt_q <= event_cnt_d;
        end
    end

    assign event_count = event_cnt_q;
`endif
endmodule
